// File: rtl/gbar_sync_unit_if.sv
// Global-barrier bus between the per-socket gbar arbiter (master) and the
// barrier sync unit (slave): arrival requests in, release broadcast out.
interface gbar_sync_unit_if #(
  parameter int NUM_CORES    = 4,
  parameter int NUM_BARRIERS = 8,
  parameter int CID_W        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  parameter int BID_W        = $clog2(NUM_BARRIERS)
);
  logic             req_valid;
  logic [BID_W-1:0] req_id;
  logic [CID_W-1:0] req_size_m1;
  logic [CID_W-1:0] req_core_id;
  logic             req_ready;
  logic             rsp_valid;
  logic [BID_W-1:0] rsp_id;

  modport master (
    output req_valid, req_id, req_size_m1, req_core_id,
    input  req_ready, rsp_valid, rsp_id
  );

  modport slave (
    input  req_valid, req_id, req_size_m1, req_core_id,
    output req_ready, rsp_valid, rsp_id
  );
endinterface

// File: rtl/gbar_sync_unit.sv
// Global barrier controller: counts per-ID core arrivals and broadcasts a
// one-cycle release when the expected count is reached, freeing the entry.
module gbar_sync_unit #(
  parameter int NUM_CORES    = 4,
  parameter int NUM_BARRIERS = 8,
  parameter int CID_W        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  parameter int BID_W        = $clog2(NUM_BARRIERS)
) (
  input  logic           clk,
  input  logic           reset,
  gbar_sync_unit_if.slave bus,
  output logic           busy,
  output logic           err_dup
);
  localparam logic [CID_W:0] ONE         = (CID_W+1)'(1);
  localparam logic [CID_W:0] NUM_CORES_W = (CID_W+1)'(NUM_CORES);

  logic [NUM_BARRIERS-1:0]                active_q, active_d;
  logic [NUM_BARRIERS-1:0][CID_W-1:0]     size_q, size_d;
  logic [NUM_BARRIERS-1:0][CID_W:0]       count_q, count_d;
  logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] mask_q, mask_d;
  logic                                   rsp_valid_q, rsp_valid_d;
  logic [BID_W-1:0]                       rsp_id_q, rsp_id_d;
  logic                                   busy_q, busy_d;
  logic                                   err_dup_q, err_dup_d;

  logic                 accept;
  logic [BID_W-1:0]     e;
  logic [NUM_CORES-1:0] core_oh;
  logic                 dup;
  logic [CID_W-1:0]     size_eff;
  logic [CID_W:0]       new_count;
  logic [NUM_CORES-1:0] mask_new;

  // Ready is only withheld while reset is held; there is no internal stall.
  assign bus.req_ready = !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    active_d    = active_q;
    size_d      = size_q;
    count_d     = count_q;
    mask_d      = mask_q;
    err_dup_d   = err_dup_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    e           = bus.req_id;
    core_oh     = NUM_CORES'(1) << bus.req_core_id;
    dup         = 1'b0;
    size_eff    = size_q[e];
    new_count   = count_q[e] + ONE;
    mask_new    = mask_q[e] | core_oh;

    if (accept) begin
      if (!active_q[e]) begin
        // First arrival opens a new epoch and fixes the expected size.
        size_eff  = bus.req_size_m1;
        new_count = ONE;
        mask_new  = core_oh;
      end else if (|(mask_q[e] & core_oh)) begin
        dup = 1'b1;
      end

      if (dup) begin
        err_dup_d = 1'b1;
      end else if (new_count == ({1'b0, size_eff} + ONE)) begin
        active_d[e] = 1'b0;
        size_d[e]   = '0;
        count_d[e]  = '0;
        mask_d[e]   = '0;
        rsp_valid_d = 1'b1;
        rsp_id_d    = e;
      end else begin
        active_d[e] = 1'b1;
        size_d[e]   = size_eff;
        count_d[e]  = new_count;
        mask_d[e]   = mask_new;
      end
    end

    busy_d = (|active_d) | rsp_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q    <= '0;
      size_q      <= '0;
      count_q     <= '0;
      mask_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
      err_dup_q   <= 1'b0;
    end else begin
      active_q    <= active_d;
      size_q      <= size_d;
      count_q     <= count_d;
      mask_q      <= mask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      busy_q      <= busy_d;
      err_dup_q   <= err_dup_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = busy_q;
  assign err_dup       = err_dup_q;

  a_core_id_range: assert property (@(posedge clk) disable iff (reset)
    bus.req_valid |-> ({1'b0, bus.req_core_id} < NUM_CORES_W));

endmodule

// File: tb/tb_gbar_sync_unit.sv
// Directed bench for gbar_sync_unit: a queue-based barrier model is checked
// against the DUT every cycle, plus literal expectations at key cycles.
module tb_gbar_sync_unit;
  localparam int NC = 4;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, err_dup;

  always #5 clk = ~clk;

  gbar_sync_unit_if #(.NUM_CORES(NC), .NUM_BARRIERS(NB)) bus ();

  gbar_sync_unit #(.NUM_CORES(NC), .NUM_BARRIERS(NB)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .busy    (busy),
    .err_dup (err_dup)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per barrier, whether open, the first-arrival size, and the list
  // of cores that have arrived in the current epoch.
  bit m_open[NB];
  int m_size[NB];
  int m_arrived[NB][$];
  bit exp_rsp_valid;
  int exp_rsp_id;
  bit exp_err;
  bit exp_busy;
  bit started = 1'b0;
  int rel_seen = 0;

  always @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NB; b++) begin
        m_open[b] = 1'b0;
        m_arrived[b].delete();
      end
      exp_rsp_valid = 1'b0;
      exp_rsp_id    = 0;
      exp_err       = 1'b0;
    end else begin
      exp_rsp_valid = 1'b0;
      if (bus.req_valid) begin
        int b;
        int c;
        bit seen;
        b = int'(bus.req_id);
        c = int'(bus.req_core_id);
        seen = 1'b0;
        if (!m_open[b]) begin
          m_open[b] = 1'b1;
          m_size[b] = int'(bus.req_size_m1) + 1;
          m_arrived[b].delete();
        end else begin
          foreach (m_arrived[b][k]) if (m_arrived[b][k] == c) seen = 1'b1;
        end
        if (seen) exp_err = 1'b1;
        else m_arrived[b].push_back(c);
        if (m_arrived[b].size() == m_size[b]) begin
          m_open[b] = 1'b0;
          m_arrived[b].delete();
          exp_rsp_valid = 1'b1;
          exp_rsp_id    = b;
        end
      end
    end
    exp_busy = exp_rsp_valid;
    for (int b = 0; b < NB; b++) if (m_open[b]) exp_busy = 1'b1;
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", int'(bus.req_ready), int'(!reset));
      chk("rsp_valid", int'(bus.rsp_valid), int'(exp_rsp_valid));
      if (exp_rsp_valid) chk("rsp_id", int'(bus.rsp_id), exp_rsp_id);
      chk("busy", int'(busy), int'(exp_busy));
      chk("err_dup", int'(err_dup), int'(exp_err));
      if (bus.rsp_valid) rel_seen++;
    end
  end

  // Called at a negedge; drives 1 time unit later, returns at next negedge.
  task automatic arrive(input int id, input int sz, input int core);
    #1;
    bus.req_valid   = 1'b1;
    bus.req_id      = 3'(id);
    bus.req_size_m1 = 2'(sz);
    bus.req_core_id = 2'(core);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", int'(bus.req_ready), 0);
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_id      = '0;
    bus.req_size_m1 = '0;
    bus.req_core_id = '0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_dup), 0);
    chk("rst_ready_hi", int'(bus.req_ready), 0);
    #1;
    reset = 1'b0;
    @(negedge clk);
    idle(1);

    // 1: four cores, one barrier
    arrive(3, 3, 0);
    chk("t1_busy_c0", int'(busy), 1);
    arrive(3, 3, 1);
    arrive(3, 3, 2);
    chk("t1_no_rel", int'(bus.rsp_valid), 0);
    arrive(3, 3, 3);
    chk("t1_rel", int'(bus.rsp_valid), 1);
    chk("t1_rel_id", int'(bus.rsp_id), 3);
    chk("t1_busy_rel", int'(busy), 1);
    idle(1);
    chk("t1_pulse_end", int'(bus.rsp_valid), 0);
    chk("t1_busy_end", int'(busy), 0);

    // 2: single-core barrier, then immediate reuse of the entry
    arrive(5, 0, 2);
    chk("t2_rel", int'(bus.rsp_valid), 1);
    chk("t2_rel_id", int'(bus.rsp_id), 5);
    arrive(5, 1, 0);
    chk("t2_fresh", int'(bus.rsp_valid), 0);
    chk("t2_busy", int'(busy), 1);
    arrive(5, 1, 1);
    chk("t2_rel2", int'(bus.rsp_valid), 1);
    idle(2);

    // 3: interleaved barriers release on consecutive cycles
    arrive(1, 1, 0);
    arrive(2, 1, 2);
    arrive(1, 1, 1);
    chk("t3_rel_a", int'(bus.rsp_id), 1);
    arrive(2, 1, 3);
    chk("t3_rel_b_v", int'(bus.rsp_valid), 1);
    chk("t3_rel_b", int'(bus.rsp_id), 2);
    idle(2);

    // 4: duplicate arrival is flagged and not counted
    arrive(4, 2, 1);
    arrive(4, 2, 1);
    chk("t4_err", int'(err_dup), 1);
    arrive(4, 2, 0);
    chk("t4_no_rel", int'(bus.rsp_valid), 0);
    arrive(4, 2, 2);
    chk("t4_rel", int'(bus.rsp_valid), 1);
    chk("t4_rel_id", int'(bus.rsp_id), 4);
    idle(2);
    chk("t4_sticky", int'(err_dup), 1);

    // 5: reset mid-barrier discards partial arrivals
    pulse_reset();
    chk("t5_err_clr", int'(err_dup), 0);
    arrive(6, 3, 0);
    arrive(6, 3, 1);
    pulse_reset();
    chk("t5_busy_clr", int'(busy), 0);
    arrive(6, 1, 2);
    chk("t5_no_rel", int'(bus.rsp_valid), 0);
    arrive(6, 1, 3);
    chk("t5_rel", int'(bus.rsp_valid), 1);
    chk("t5_rel_id", int'(bus.rsp_id), 6);
    chk("t5_err", int'(err_dup), 0);
    idle(2);

    // 6: first arrival's size is authoritative
    arrive(0, 1, 0);
    arrive(0, 3, 1);
    chk("t6_rel", int'(bus.rsp_valid), 1);
    chk("t6_rel_id", int'(bus.rsp_id), 0);
    idle(1);

    // back-to-back completions of the same ID
    arrive(7, 0, 0);
    arrive(7, 0, 1);
    chk("b2b_rel2", int'(bus.rsp_valid), 1);
    chk("b2b_rel2_id", int'(bus.rsp_id), 7);
    idle(3);

    chk("release_total", rel_seen, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
